// File: rtl/comp_mem_pkg.sv
// Shared definitions for the compensation weight store (read and write sides).
package comp_mem_pkg;

    localparam int unsigned SIZE       = 8;
    localparam int unsigned COMP_DEPTH = 3;
    localparam int unsigned CW         = 3;
    localparam int unsigned AW         = $clog2(SIZE * COMP_DEPTH);
    localparam int unsigned COLW       = $clog2(SIZE);
    localparam int unsigned KW         = $clog2(COMP_DEPTH);
    localparam int unsigned WW         = COMP_DEPTH * CW;

    // One column's packed entries: entry k lives in bits [k*CW +: CW]
    typedef logic [WW-1:0] comp_col_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        DONE
    } comp_state_t;

endpackage

// File: rtl/comp_col_packer.sv
// Column pack register(s) for the compensation reader.
// COMP_READ_PREFETCH_EN adds a second buffer with separate write/read select.
module comp_col_packer
    import comp_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [KW-1:0] i_wr_slot,
    input  logic [CW-1:0] i_wr_data,
`ifdef COMP_READ_PREFETCH_EN
    input  logic          i_wr_buf,
    input  logic          i_rd_buf,
`endif
    output comp_col_t     o_word
);

`ifdef COMP_READ_PREFETCH_EN
    logic [1:0][WW-1:0] r_buf;

    // Write one slot of the selected fill buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
        end else if (i_wr_en) begin
            r_buf[i_wr_buf][i_wr_slot*CW +: CW] <= i_wr_data;
        end
    end

    assign o_word = r_buf[i_rd_buf];
`else
    comp_col_t r_pack;

    // Write one slot of the single pack register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack <= '0;
        end else if (i_wr_en) begin
            r_pack[i_wr_slot*CW +: CW] <= i_wr_data;
        end
    end

    assign o_word = r_pack;
`endif

endmodule

// File: rtl/compensation_mem_reader.sv
// Read-side engine for the compensation weight store: walks all columns,
// fetches COMP_DEPTH entries per column and presents each packed column
// over valid/ready. Optional COMP_READ_PREFETCH_EN overlaps the fetch of
// column c+1 with the presentation of column c.
module compensation_mem_reader
    import comp_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [CW-1:0]   rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WW-1:0]   out_data,
    output logic [COLW-1:0] out_col,
    output logic            busy,
    output logic            done
);

    comp_state_t     r_state;
    logic [COLW-1:0] r_col;
    logic [KW-1:0]   r_k;
    logic            r_pend;
    logic [KW-1:0]   r_pend_slot;
    logic            w_last_col;
    logic            w_last_k;

`ifdef COMP_READ_PREFETCH_EN
    typedef enum logic [1:0] {
        PF_NONE,
        PF_ISSUE,
        PF_TAIL,
        PF_READY
    } pf_state_t;

    pf_state_t r_pf;
    logic      r_wr_buf;
    logic      r_rd_buf;
`endif

    assign w_last_col = (r_col == COLW'(SIZE - 1));
    assign w_last_k   = (r_k == KW'(COMP_DEPTH - 1));
    assign busy       = (r_state != IDLE);
    assign out_col    = r_col;

    // Track the slot of each issued read so the data lands one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_slot <= '0;
        end else begin
            r_pend      <= rd_en;
            r_pend_slot <= r_k;
        end
    end

    comp_col_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_pend),
        .i_wr_slot (r_pend_slot),
        .i_wr_data (rd_data),
`ifdef COMP_READ_PREFETCH_EN
        .i_wr_buf  (r_wr_buf),
        .i_rd_buf  (r_rd_buf),
`endif
        .o_word    (out_data)
    );

    // Column walk FSM with registered read-port and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_col     <= '0;
            r_k       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef COMP_READ_PREFETCH_EN
            r_pf      <= PF_NONE;
            r_wr_buf  <= 1'b0;
            r_rd_buf  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_col   <= '0;
                        r_k     <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end

                FETCH: begin
                    if (w_last_k) begin
                        rd_en   <= 1'b0;
                        r_state <= WAIT;
                    end else begin
                        r_k     <= r_k + KW'(1);
                        rd_addr <= rd_addr + AW'(1);
                    end
                end

                WAIT: begin
                    r_state   <= PRESENT;
                    out_valid <= 1'b1;
`ifdef COMP_READ_PREFETCH_EN
                    r_rd_buf <= r_wr_buf;
                    if (!w_last_col) begin
                        r_wr_buf <= ~r_wr_buf;
                        r_pf     <= PF_ISSUE;
                        r_k      <= '0;
                        rd_en    <= 1'b1;
                        rd_addr  <= rd_addr + AW'(1);
                    end else begin
                        r_pf <= PF_NONE;
                    end
`endif
                end

                PRESENT: begin
`ifdef COMP_READ_PREFETCH_EN
                    // Background fetch of the next column into the other buffer
                    case (r_pf)
                        PF_ISSUE: begin
                            if (w_last_k) begin
                                rd_en <= 1'b0;
                                r_pf  <= PF_TAIL;
                            end else begin
                                r_k     <= r_k + KW'(1);
                                rd_addr <= rd_addr + AW'(1);
                            end
                        end
                        PF_TAIL: r_pf <= PF_READY;
                        default: ;
                    endcase
`endif
                    if (out_ready) begin
                        if (w_last_col) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_col <= r_col + COLW'(1);
`ifdef COMP_READ_PREFETCH_EN
                            // TAIL completes its last capture on this same edge
                            if (r_pf == PF_TAIL || r_pf == PF_READY) begin
                                r_rd_buf <= r_wr_buf;
                                if (r_col != COLW'(SIZE - 2)) begin
                                    r_wr_buf <= ~r_wr_buf;
                                    r_pf     <= PF_ISSUE;
                                    r_k      <= '0;
                                    rd_en    <= 1'b1;
                                    rd_addr  <= rd_addr + AW'(1);
                                end else begin
                                    r_pf <= PF_NONE;
                                end
                            end else begin
                                out_valid <= 1'b0;
                                r_pf      <= PF_NONE;
                                r_state   <= w_last_k ? WAIT : FETCH;
                            end
`else
                            out_valid <= 1'b0;
                            r_k       <= '0;
                            rd_en     <= 1'b1;
                            rd_addr   <= rd_addr + AW'(1);
                            r_state   <= FETCH;
`endif
                        end
                    end
                end

                DONE: r_state <= IDLE;

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/compensation_mem_reader.md
Name: compensation_mem_reader

Overview:
Read-side engine for the 8x8 array's compensation weight store (SIZE columns x COMP_DEPTH 3-bit entries, column-major, address = col*COMP_DEPTH + k). On a start pulse it walks every column and fetches that column's COMP_DEPTH entries over a synchronous 1-cycle-latency read port. It packs them into one word and hands each column to the compensation datapath over a valid/ready interface. It pulses done after the last column.

Parameters:
SIZE, 8, number of array columns
COMP_DEPTH, 3, compensation entries per column
CW, 3, compensation weight width in bits
AW, $clog2(SIZE*COMP_DEPTH) = 5, memory address width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to read all columns; honoured only in IDLE
rd_en  out  1  memory read enable
rd_addr  out  AW  memory read address
rd_data  in  CW  memory read data, valid the cycle after rd_en
out_valid  out  1  packed column word available
out_ready  in  1  consumer accepts word
out_data  out  COMP_DEPTH*CW  entry k in bits [k*CW +: CW]
out_col  out  $clog2(SIZE)  column index of out_data
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse after last column accepted

Behaviour:
- Reset (async): state=IDLE, col=0, k=0, all outputs 0, pack register 0.
- Outputs are registered (rd_en, rd_addr, out_valid, done) or driven directly from state/col registers. No combinational path from out_ready to out_valid or out_data.
- States:
  - IDLE: start=1 -> FETCH, col=0, k=0.
  - FETCH: rd_en=1, rd_addr=col*COMP_DEPTH+k, k increments each cycle; after k=COMP_DEPTH-1 issued -> WAIT.
  - WAIT: captures final rd_data; -> PRESENT.
  - PRESENT: out_valid=1, out_data and out_col stable until handshake.
  - DONE: done=1 for exactly one cycle; -> IDLE.
- rd_data captured into slot k-1 on the edge after each issue; slot COMP_DEPTH-1 captured at the WAIT edge.
- PRESENT handshake (out_valid&out_ready at edge):
  - col==SIZE-1 -> DONE.
  - otherwise col+1, k=0 -> FETCH.
- Latency: start sampled at edge E0; reads issued in the cycles after E0..E2; out_valid high after E4. Column-to-column cost = COMP_DEPTH+2 cycles plus stall.
- Back-pressure: out_ready low holds PRESENT indefinitely, and out_data/out_col do not change.
- Ignored events:
  - start outside IDLE is ignored, including in the DONE cycle.
  - out_ready outside PRESENT has no effect.
- Address never exceeds SIZE*COMP_DEPTH-1; col never wraps within a pass and returns to 0 only on a new start.
- Reset mid-pass aborts immediately: no done pulse, outputs 0; the next start begins at col 0.

Optional Feature:
COMP_READ_PREFETCH_EN
- Defined: second pack buffer. While in PRESENT for column c (c<SIZE-1), column c+1 is fetched into the alternate buffer. On the handshake, if the prefetch is complete, out_valid stays high the next cycle with column c+1 (zero bubble). If the prefetch is incomplete, out_valid drops until the WAIT capture. Steady-state column period = max(COMP_DEPTH+1, consumer rate). Prefetch never issues reads beyond the last column.
- Undefined: single buffer, behaviour exactly as above.

Decomposition:
- Shared package comp_mem_pkg: SIZE, COMP_DEPTH, CW, AW; state enum {IDLE, FETCH, WAIT, PRESENT, DONE}; packed word type comp_col_t of COMP_DEPTH*CW bits. The same package serves the write-side memory.
- One sub-module: comp_col_packer. It holds the pack register(s), slot write by index, and buffer select for prefetch. The FSM/counters stay in the top module.

Test Plan:
1. Memory model holds mem[a]=a%8. start, out_ready=1 -> column 0 out_data={3'd2,3'd1,3'd0}, out_valid first high 5 cycles after start. Column 7 = {3'd7,3'd6,3'd5} (addr 21..23). done pulses once, busy falls the next cycle.
2. out_ready=0 for 10 cycles on column 3 -> out_valid held, out_data/out_col=3 constant, rd_en=0 throughout the stall.
3. start pulsed again mid-pass (column 4) -> ignored: all 8 columns still delivered exactly once, single done.
4. rst asserted while in FETCH for column 5 -> all outputs 0 immediately, no done. A new start delivers columns 0..7 correctly.
5. Address sweep: log rd_addr -> exactly 0..23 in order, each once per pass, never >23.
6. With COMP_READ_PREFETCH_EN and out_ready=1 -> 8 columns in 8*(COMP_DEPTH+1)+2 cycles or fewer, data identical to scenario 1.
